// File: rtl/operand_sequencer_pkg.sv
// Shared widths, state encoding and register-slot indices for the operand sequencer.
// The optional accumulate feature is enabled by defining OPSEQ_ACCUM_EN.
package operand_sequencer_pkg;

    localparam int OPSEQ_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_LOAD_A = 2'd0,
        ST_LOAD_B = 2'd1,
        ST_ADD    = 2'd2,
        ST_HOLD   = 2'd3
    } opseq_state_e;

    // Slots of the load-enable register bank inside the top.
    localparam int REG_OPA    = 0;
    localparam int REG_OPB    = 1;
    localparam int REG_RESULT = 2;
    localparam int NUM_REGS   = 3;

endpackage

// File: rtl/operand_sequencer_en_reg8.sv
// Load-enable data register with asynchronous active-low clear; holds its value when en=0.
module en_reg8
    import operand_sequencer_pkg::*;
#(
    parameter int W = OPSEQ_WIDTH
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = en ? d : data_q;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/operand_sequencer.sv
// Serial two-operand loader around an external 8-bit adder; holds the sum until acknowledged.
// Defining OPSEQ_ACCUM_EN adds accumMode, which chains the held result back in as operand A.
module operand_sequencer
    import operand_sequencer_pkg::*;
#(
    parameter int WIDTH = OPSEQ_WIDTH
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [WIDTH-1:0] dIn,
    input  logic             dValid,
    output logic             dReady,
    output logic [WIDTH-1:0] opA,
    output logic [WIDTH-1:0] opB,
    output logic             addEnable,
    input  logic [WIDTH-1:0] sum,
    input  logic             carry,
`ifdef OPSEQ_ACCUM_EN
    input  logic             accumMode,
`endif
    output logic [WIDTH-1:0] result,
    output logic             resultCarry,
    output logic             resultValid,
    input  logic             resultAck
);

    opseq_state_e state_q, state_d;
    logic         add_enable_q, add_enable_d;
    logic         result_valid_q, result_valid_d;
    logic         result_carry_q, result_carry_d;
    logic         accum_sel;

    logic [NUM_REGS-1:0] reg_en;
    logic [WIDTH-1:0]    reg_d [NUM_REGS];
    logic [WIDTH-1:0]    reg_q [NUM_REGS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            en_reg8 #(.W(WIDTH)) u_reg (
                .clk  (clk),
                .rstN (rstN),
                .en   (reg_en[gi]),
                .d    (reg_d[gi]),
                .q    (reg_q[gi])
            );
        end
    endgenerate

`ifdef OPSEQ_ACCUM_EN
    assign accum_sel = accumMode;
`else
    assign accum_sel = 1'b0;
`endif

    always_comb begin
        state_d            = state_q;
        add_enable_d       = 1'b0;
        result_valid_d     = result_valid_q;
        result_carry_d     = result_carry_q;
        reg_en             = '0;
        reg_d[REG_OPA]     = dIn;
        reg_d[REG_OPB]     = dIn;
        reg_d[REG_RESULT]  = sum;

        case (state_q)
            ST_LOAD_A: begin
                if (dValid) begin
                    reg_en[REG_OPA] = 1'b1;
                    state_d         = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                if (dValid) begin
                    reg_en[REG_OPB] = 1'b1;
                    add_enable_d    = 1'b1;
                    state_d         = ST_ADD;
                end
            end
            ST_ADD: begin
                reg_en[REG_RESULT] = 1'b1;
                result_carry_d     = carry;
                result_valid_d     = 1'b1;
                state_d            = ST_HOLD;
            end
            ST_HOLD: begin
                if (resultAck) begin
                    result_valid_d = 1'b0;
                    // Running sum: the held result becomes operand A; carry is dropped.
                    if (accum_sel) begin
                        reg_en[REG_OPA] = 1'b1;
                        reg_d[REG_OPA]  = reg_q[REG_RESULT];
                        state_d         = ST_LOAD_B;
                    end else begin
                        state_d = ST_LOAD_A;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD_A;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q        <= ST_LOAD_A;
            add_enable_q   <= 1'b0;
            result_valid_q <= 1'b0;
            result_carry_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            add_enable_q   <= add_enable_d;
            result_valid_q <= result_valid_d;
            result_carry_q <= result_carry_d;
        end
    end

    assign dReady      = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
    assign addEnable   = add_enable_q;
    assign resultValid = result_valid_q;
    assign resultCarry = result_carry_q;
    assign opA         = reg_q[REG_OPA];
    assign opB         = reg_q[REG_OPB];
    assign result      = reg_q[REG_RESULT];

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer with a behavioural adder; accumulate test runs when
// OPSEQ_ACCUM_EN is defined.
module tb_operand_sequencer;

    logic       clk;
    logic       rstN;
    logic [7:0] dIn;
    logic       dValid;
    logic       dReady;
    logic [7:0] opA;
    logic [7:0] opB;
    logic       addEnable;
    logic [7:0] sum;
    logic       carry;
    logic [7:0] result;
    logic       resultCarry;
    logic       resultValid;
    logic       resultAck;
    logic       accumMode;
    logic [8:0] full_sum;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_r;
        logic       exp_c;
    } vec_t;

    vec_t vecs[6];

    operand_sequencer dut (
        .clk         (clk),
        .rstN        (rstN),
        .dIn         (dIn),
        .dValid      (dValid),
        .dReady      (dReady),
        .opA         (opA),
        .opB         (opB),
        .addEnable   (addEnable),
        .sum         (sum),
        .carry       (carry),
`ifdef OPSEQ_ACCUM_EN
        .accumMode   (accumMode),
`endif
        .result      (result),
        .resultCarry (resultCarry),
        .resultValid (resultValid),
        .resultAck   (resultAck)
    );

    // Adder model: outputs zero while not enabled.
    assign full_sum = {1'b0, opA} + {1'b0, opB};
    assign sum      = addEnable ? full_sum[7:0] : 8'h00;
    assign carry    = addEnable ? full_sum[8] : 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in LOAD_A just after an edge; ends in HOLD just after an edge.
    task automatic send_pair(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] exp_r, input logic exp_c, input string tag);
        check({tag, " ready_a"}, 32'(dReady), 32'd1);
        dIn = a; dValid = 1'b1;
        step();
        check({tag, " ready_b"}, 32'(dReady), 32'd1);
        dIn = b;
        step();
        dValid = 1'b0;
        check({tag, " add_en"}, 32'(addEnable), 32'd1);
        check({tag, " valid_early"}, 32'(resultValid), 32'd0);
        step();
        check({tag, " add_en_off"}, 32'(addEnable), 32'd0);
        check({tag, " valid"}, 32'(resultValid), 32'd1);
        check({tag, " result"}, 32'(result), 32'(exp_r));
        check({tag, " carry"}, 32'(resultCarry), 32'(exp_c));
        check({tag, " ready_hold"}, 32'(dReady), 32'd0);
    endtask

    task automatic ack(input string tag);
        resultAck = 1'b1;
        step();
        resultAck = 1'b0;
        check({tag, " valid_clr"}, 32'(resultValid), 32'd0);
        check({tag, " ready_after"}, 32'(dReady), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{8'h12, 8'h34, 8'h46, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b1};
        vecs[3] = '{8'h7F, 8'h01, 8'h80, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[5] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};

        rstN = 1'b0; dIn = 8'h00; dValid = 1'b0; resultAck = 1'b0; accumMode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst opA", 32'(opA), 32'd0);
        check("rst opB", 32'(opB), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst flags", {29'd0, addEnable, resultValid, resultCarry}, 32'd0);
        rstN = 1'b1;
        step();
        check("rst ready", 32'(dReady), 32'd1);

        for (int i = 0; i < 6; i++) begin
            send_pair(vecs[i].a, vecs[i].b, vecs[i].exp_r, vecs[i].exp_c, $sformatf("vec%0d", i));
            ack($sformatf("vec%0d", i));
        end

        // Held result stays stable while unacknowledged.
        send_pair(8'hFF, 8'h01, 8'h00, 1'b1, "hold");
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("hold c%0d", i),
                  {22'd0, resultValid, resultCarry, dReady, result}, {22'd0, 1'b1, 1'b1, 1'b0, 8'h00});
        end
        ack("hold");

        // dValid during ADD/HOLD is ignored.
        dIn = 8'h11; dValid = 1'b1;
        step();
        dIn = 8'h22;
        step();
        dIn = 8'hAA;
        check("ign add_en", 32'(addEnable), 32'd1);
        step();
        check("ign result", 32'(result), 32'h33);
        step();
        check("ign opA", 32'(opA), 32'h11);
        check("ign opB", 32'(opB), 32'h22);
        dValid = 1'b0;
        ack("ign");
        send_pair(8'h44, 8'h01, 8'h45, 1'b0, "ign next");
        check("ign next opA", 32'(opA), 32'h44);
        ack("ign next");

        // Reset while waiting for operand B.
        dIn = 8'h55; dValid = 1'b1;
        step();
        dValid = 1'b0;
        check("mid opA", 32'(opA), 32'h55);
        rstN = 1'b0;
        #1;
        check("mid rst opA", 32'(opA), 32'd0);
        check("mid rst opB", 32'(opB), 32'd0);
        check("mid rst result", 32'(result), 32'd0);
        check("mid rst flags", {29'd0, addEnable, resultValid, resultCarry}, 32'd0);
        step();
        rstN = 1'b1;
        step();
        check("mid ready", 32'(dReady), 32'd1);
        step();
        check("mid no add", 32'(addEnable), 32'd0);
        send_pair(8'h01, 8'h02, 8'h03, 1'b0, "mid pair");
        ack("mid pair");

        // Stray ack in LOAD_A.
        resultAck = 1'b1;
        step();
        resultAck = 1'b0;
        check("stray valid", 32'(resultValid), 32'd0);
        check("stray ready", 32'(dReady), 32'd1);
        check("stray opA", 32'(opA), 32'h01);

        // Back-to-back with ack held high: one result every 4 cycles.
        resultAck = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dIn = 8'(8'h10 * (i + 1)); dValid = 1'b1;
            step();
            dIn = 8'h03;
            step();
            dValid = 1'b0;
            check($sformatf("b2b%0d add_en", i), 32'(addEnable), 32'd1);
            step();
            check($sformatf("b2b%0d result", i), {23'd0, resultValid, result},
                  {23'd0, 1'b1, 8'(8'h10 * (i + 1) + 8'h03)});
            step();
            check($sformatf("b2b%0d back", i), {30'd0, dReady, resultValid}, {30'd0, 1'b1, 1'b0});
        end
        resultAck = 1'b0;

`ifdef OPSEQ_ACCUM_EN
        send_pair(8'h10, 8'h20, 8'h30, 1'b0, "acc first");
        accumMode = 1'b1; resultAck = 1'b1;
        step();
        resultAck = 1'b0; accumMode = 1'b0;
        check("acc opA", 32'(opA), 32'h30);
        check("acc ready", 32'(dReady), 32'd1);
        dIn = 8'h05; dValid = 1'b1;
        step();
        dValid = 1'b0;
        check("acc add_en", 32'(addEnable), 32'd1);
        step();
        check("acc result", {23'd0, resultValid, result}, {23'd0, 1'b1, 8'h35});
        ack("acc");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
